// File: rtl/imem_loader.sv
// Byte-stream to 32-bit word loader: packs little-endian bytes and writes them sequentially into instruction memory.
// Latency: a word is written in the cycle after its 4th (or last) byte is accepted; 5 cycles per word minimum.
// Backpressure: byte_ready_o drops during the write cycle and stays low once done or overflowed, until reset.
module imem_loader #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              write_en_o,
    output logic              read_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [AWIDTH-1:0] word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    localparam logic [AWIDTH-1:0] MAX_W = AWIDTH'(MAX_WORDS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_idx;
    logic [DWIDTH-1:0]   r_asm;
    logic [AWIDTH-1:0]   r_cnt;
    logic                r_last;
    logic                w_ready;
    logic                w_accept;
    logic                w_can_write;
    logic                w_wr;

    assign w_accept    = byte_valid_i && w_ready;
    assign w_can_write = (r_cnt < MAX_W);

    // State register; reset discards any partial word or pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = byte_last_i ? S_WRITE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_ready = 1'b1;
                if (w_accept && (byte_last_i || r_idx == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_can_write) begin
                    w_wr        = 1'b1;
                    w_state_nxt = r_last ? S_DONE : S_COLLECT;
                end else begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte assembly, last-flag latch and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_asm  <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm[{r_idx, 3'b000} +: 8] <= byte_data_i;
                r_idx                       <= r_idx + 2'd1;
                if (byte_last_i) begin
                    r_last <= 1'b1;
                end
            end
            if (w_wr) begin
                r_cnt <= r_cnt + 1'b1;
                r_asm <= '0;
                r_idx <= 2'd0;
            end
        end
    end

    assign byte_ready_o = w_ready;
    assign write_en_o   = w_wr;
    // Address and data are forced to zero outside the write strobe
    assign addr_o       = w_wr ? (BASE_ADDR + (r_cnt << 2)) : '0;
    assign data_o       = w_wr ? r_asm : '0;
    assign read_en_o    = 1'b0;
    assign busy_o       = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign done_o       = (r_state == S_DONE);
    assign overflow_o   = (r_state == S_ERROR);
    assign word_count_o = r_cnt;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the instruction fetch path.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into the memory block through its addr/data/write-enable port.
- Used at bring-up to load a program image before fetch starts; done_o tells the top level the image is in place.

Parameters:
- AWIDTH, 32, address width of the memory port.
- DWIDTH, 32, data width of the memory port; fixed at 32 (4 bytes per word).
- BASE_ADDR, 32'h0100_0000, byte address of the first word written.
- MAX_WORDS, 1024, capacity limit in words; writes beyond it are refused.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_valid_i  input  1  upstream byte is valid.
- byte_data_i  input  8  upstream byte.
- byte_last_i  input  1  final byte of the image; qualified by byte_valid_i.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- addr_o  output  AWIDTH  memory byte address.
- data_o  output  DWIDTH  memory write data.
- write_en_o  output  1  memory write strobe, one cycle per word.
- read_en_o  output  1  tied to 0.
- busy_o  output  1  load in progress (COLLECT or WRITE).
- done_o  output  1  image fully written; sticky.
- overflow_o  output  1  capacity exceeded; sticky.
- word_count_o  output  AWIDTH  number of words written so far.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, byte index=0, assembly register=0, word count=0.
  - All outputs 0, except byte_ready_o=1.
  - Reset has priority over every other event; a partial word or a pending write is discarded.
- Handshake: a byte is accepted on a cycle where byte_valid_i && byte_ready_o.
  - byte_ready_o=1 only in IDLE and COLLECT.
  - byte_valid_i with ready low has no effect; upstream must hold the byte.
- Byte packing is little-endian: byte index k (0..3) goes to bits [8k+7:8k] of the assembly register.
- FSM states: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE:
  - First accepted byte moves to COLLECT, index=1.
  - If that byte also has byte_last_i, go straight to WRITE.
- COLLECT:
  - Each accepted byte stores at the current index, then index++.
  - Go to WRITE when the 4th byte is accepted or an accepted byte has byte_last_i.
  - A last flag is latched whenever byte_last_i is accepted.
- WRITE (exactly one cycle):
  - If word count < MAX_WORDS: write_en_o=1, addr_o = BASE_ADDR + 4*word_count, data_o = assembly register. Unfilled upper bytes of a partial final word are 0.
  - Next cycle: word count++, assembly register and index cleared. Go to DONE if the last flag is set, else COLLECT.
  - If word count == MAX_WORDS: no write, go to ERROR.
- Throughput: 4 bytes + 1 write cycle = 5 cycles per word, minimum.
- addr_o and data_o are 0 whenever write_en_o=0.
- DONE: done_o=1, byte_ready_o=0; held until reset.
- ERROR: overflow_o=1, byte_ready_o=0; held until reset. word_count_o stays at MAX_WORDS.
- busy_o=1 in COLLECT and WRITE only.
- Address arithmetic is modulo 2^AWIDTH; wrap is not flagged.
- Gaps in byte_valid_i are allowed anywhere; state is held across them.

Test Plan:
- Full-word image: bytes 13 00 00 00 93 00 10 00, last on the 8th, valid every cycle.
  -> write 0x00000013 @0x01000000, then 0x00100093 @0x01000004.
  -> done_o=1, word_count_o=2, byte_ready_o=0 afterwards.
- Partial last word: bytes AA BB CC DD 11 22, last on the 6th.
  -> writes 0xDDCCBBAA @0x01000000 and 0x00002211 @0x01000004; done_o=1.
- Backpressure: hold byte_valid_i=1 continuously across a word boundary.
  -> byte_ready_o=0 in the WRITE cycle, no byte lost or duplicated, write_en_o high exactly one cycle per word.
- Overflow, MAX_WORDS=2: send 12 bytes.
  -> two writes occur, third write suppressed, overflow_o=1, word_count_o=2, byte_ready_o stays 0.
- Reset mid-word: send 2 bytes, assert rst for 1 cycle, then send 4 bytes with last.
  -> single write of the new word @0x01000000; the old bytes do not appear.
- Sparse valid: insert random 0-3 cycle gaps between bytes.
  -> identical write sequence and data to the first scenario.
